// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
//   div_state_t : divider control FSM encoding (IDLE, RUN, FIX, DONE)
//   DIV_WIDTH   : default operand/result width
package div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;

    localparam int DIV_WIDTH = 32;

endpackage

// File: rtl/div_abs.sv
// Combinational magnitude extractor for one divider operand.
//   In     : operand as presented on the datapath
//   Signed : 1 = treat In as two's complement, 0 = unsigned
//   Mag    : |In| (unsigned); the most negative value maps to itself, which
//            is the correct unsigned magnitude
//   Neg    : 1 when In is negative under signed interpretation
module div_abs
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] In,
    input  logic             Signed,
    output logic [WIDTH-1:0] Mag,
    output logic             Neg
);

    assign Neg = Signed & In[WIDTH-1];
    assign Mag = Neg ? -In : In;

endmodule

// File: rtl/div_unit.sv
// Multicycle restoring divider (DIV/DIVU) driven by a Start/Done handshake.
//   Clk, Reset : clock (rising edge), asynchronous active-high reset
//   Start      : request, sampled only in IDLE
//   Signed     : 1 = DIV, 0 = DIVU, captured with Start
//   A, B       : dividend / divisor, captured with Start
//   Hi, Lo     : remainder / quotient, updated only when a division completes
//   Busy       : high while iterating (RUN) and sign fix-up (FIX)
//   Done       : one-cycle completion pulse
//   DivZero    : high alongside Done when the captured divisor was zero
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH);

    div_state_t state, state_nxt;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic             neg_a_in, neg_b_in;

    logic [WIDTH-1:0] quo;       // dividend shifts out the top, quotient bits enter at bit 0
    logic [WIDTH-1:0] rem;       // partial remainder, always < divisor so WIDTH bits suffice
    logic [WIDTH-1:0] dvs;       // divisor magnitude
    logic             neg_a, neg_b;
    logic [CW-1:0]    cnt;
    logic             dz;

    // Shifted remainder needs one extra bit: with a divisor near 2^WIDTH the
    // shifted value can exceed WIDTH bits before the subtraction.
    logic [WIDTH:0]   rem_shift;
    logic             fits;
    logic [WIDTH-1:0] rem_sub;

    div_abs #(.WIDTH(WIDTH)) u_abs_a (.In(A), .Signed(Signed), .Mag(mag_a), .Neg(neg_a_in));
    div_abs #(.WIDTH(WIDTH)) u_abs_b (.In(B), .Signed(Signed), .Mag(mag_b), .Neg(neg_b_in));

    assign rem_shift = {rem, quo[WIDTH-1]};
    assign fits      = rem_shift >= {1'b0, dvs};
    // Result of the subtraction is below the divisor, so the low WIDTH bits are exact.
    assign rem_sub   = rem_shift[WIDTH-1:0] - dvs;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) state_nxt = (B == '0) ? DONE : RUN;
            end
            RUN: begin
                Busy = 1'b1;
                if (cnt == '0) state_nxt = FIX;
            end
            FIX: begin
                Busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign DivZero = dz;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            cnt   <= '0;
            dz    <= 1'b0;
            Hi    <= '0;
            Lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (B == '0) begin
                            dz <= 1'b1;
                        end else begin
                            quo   <= mag_a;
                            dvs   <= mag_b;
                            neg_a <= neg_a_in;
                            neg_b <= neg_b_in;
                            rem   <= '0;
                            cnt   <= CW'(WIDTH - 1);
                        end
                    end
                end
                RUN: begin
                    quo <= {quo[WIDTH-2:0], fits};
                    rem <= fits ? rem_sub : rem_shift[WIDTH-1:0];
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                FIX: begin
                    // Quotient truncates toward zero; remainder follows the dividend's sign.
                    Lo <= (neg_a ^ neg_b) ? -quo : quo;
                    Hi <= neg_a ? -rem : rem;
                end
                DONE: begin
                    dz <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Signed;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;
    logic        DivZero;

    int tests = 0;
    int fails = 0;

    div_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Signed(Signed),
        .A(A), .B(B), .Hi(Hi), .Lo(Lo),
        .Busy(Busy), .Done(Done), .DivZero(DivZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: divide magnitudes with wide integers, then apply signs.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output logic [31:0] q, output logic [31:0] r);
        longint ma, mb, mq, mr;
        bit na, nb;
        na = sgn && a[31];
        nb = sgn && b[31];
        ma = na ? -longint'($signed(a)) : longint'(a);
        mb = nb ? -longint'($signed(b)) : longint'(b);
        mq = ma / mb;
        mr = ma % mb;
        if (na ^ nb) mq = -mq;
        if (na) mr = -mr;
        q = 32'(mq);
        r = 32'(mr);
    endfunction

    // Issue one request and wait (bounded) for Done. lat = cycles after the
    // Start edge at which Done is seen (0 = timeout). Operand inputs are
    // scrambled while the divider runs to show they are not re-sampled.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          output int lat, output bit busy_ok,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        @(negedge Clk);
        Start = 1'b1; A = a; B = b; Signed = sgn;
        @(negedge Clk);
        Start = 1'b0;
        lat = 0; busy_ok = 1'b1; hi = '0; lo = '0; dz = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            if (Done) begin
                lat = n; hi = Hi; lo = Lo; dz = DivZero;
                if (Busy) busy_ok = 1'b0;
                break;
            end
            if (!Busy) busy_ok = 1'b0;
            A = $urandom; B = $urandom; Signed = 1'($urandom);
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; Signed = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge Clk);
        tests++;
        if ({Hi, Lo, Busy, Done, DivZero} !== '0) begin
            fails++;
            $display("FAIL reset: Hi=%h Lo=%h Busy=%b Done=%b DivZero=%b expected all zero",
                     Hi, Lo, Busy, Done, DivZero);
        end
        Reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] a_t [4] = '{32'd100, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] b_t [4] = '{32'd7,   32'd2,       32'd2,       32'hFFFFFFFF};
        logic        s_t [4] = '{1'b0,    1'b1,        1'b0,        1'b1};
        logic [31:0] q_t [4] = '{32'd14,  32'hFFFFFFFD, 32'h7FFFFFFF, 32'h80000000};
        logic [31:0] r_t [4] = '{32'd2,   32'hFFFFFFFF, 32'd1,       32'd0};
        int lat; bit bok; logic [31:0] hi, lo; logic dz;
        for (int i = 0; i < 4; i++) begin
            do_div(a_t[i], b_t[i], s_t[i], lat, bok, hi, lo, dz);
            tests++;
            if (lat !== 34 || !bok) begin
                fails++;
                $display("FAIL directed%0d_timing: done at cycle %0d busy_ok=%0b, expected cycle 34 busy_ok=1",
                         i, lat, bok);
            end
            tests++;
            if (lo !== q_t[i] || hi !== r_t[i] || dz !== 1'b0) begin
                fails++;
                $display("FAIL directed%0d_result: Lo=%h Hi=%h DivZero=%b, expected Lo=%h Hi=%h DivZero=0",
                         i, lo, hi, dz, q_t[i], r_t[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat; bit bok; logic [31:0] hi, lo; logic dz;
        do_div(32'd95, 32'd10, 1'b0, lat, bok, hi, lo, dz);
        tests++;
        if (lo !== 32'd9 || hi !== 32'd5) begin
            fails++;
            $display("FAIL dz_preload: Lo=%0d Hi=%0d, expected Lo=9 Hi=5", lo, hi);
        end
        do_div(32'd1234, 32'd0, 1'b1, lat, bok, hi, lo, dz);
        tests++;
        if (lat !== 1 || dz !== 1'b1 || hi !== 32'd5 || lo !== 32'd9) begin
            fails++;
            $display("FAIL dz_result: cycle=%0d DivZero=%b Hi=%0d Lo=%0d, expected cycle=1 DivZero=1 Hi=5 Lo=9",
                     lat, dz, hi, lo);
        end
        @(negedge Clk);
        tests++;
        if (DivZero !== 1'b0 || Done !== 1'b0) begin
            fails++;
            $display("FAIL dz_clear: DivZero=%b Done=%b after DONE, expected 0 0", DivZero, Done);
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit bok; logic [31:0] hi, lo; logic dz;
        @(negedge Clk);
        Start = 1'b1; A = 32'd50; B = 32'd7; Signed = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        Reset = 1'b1;
        #1;
        tests++;
        if (Hi !== '0 || Lo !== '0 || Busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: Hi=%h Lo=%h Busy=%b, expected 0 0 0", Hi, Lo, Busy);
        end
        @(negedge Clk);
        Reset = 1'b0;
        do_div(32'd9, 32'd3, 1'b0, lat, bok, hi, lo, dz);
        tests++;
        if (lat !== 34 || lo !== 32'd3 || hi !== 32'd0) begin
            fails++;
            $display("FAIL reset_recover: cycle=%0d Lo=%0d Hi=%0d, expected cycle=34 Lo=3 Hi=0", lat, lo, hi);
        end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        logic [31:0] hi = '0, lo = '0;
        @(negedge Clk);
        Start = 1'b1; A = 32'd1000; B = 32'd3; Signed = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            if (Done) begin
                lat = n; hi = Hi; lo = Lo;
                break;
            end
            if (n == 5) begin
                Start = 1'b1; A = 32'd77; B = 32'd0; Signed = 1'b1;
            end else if (n == 6) begin
                Start = 1'b0;
            end
            @(negedge Clk);
        end
        // Start presented while in DONE must not launch a new division.
        Start = 1'b1; A = 32'd5; B = 32'd0;
        @(negedge Clk);
        Start = 1'b0;
        tests++;
        if (lat !== 34 || lo !== 32'd333 || hi !== 32'd1) begin
            fails++;
            $display("FAIL start_ignored_result: cycle=%0d Lo=%0d Hi=%0d, expected cycle=34 Lo=333 Hi=1",
                     lat, lo, hi);
        end
        tests++;
        if (Busy !== 1'b0 || Done !== 1'b0 || DivZero !== 1'b0) begin
            fails++;
            $display("FAIL start_ignored_done: Busy=%b Done=%b DivZero=%b, expected 0 0 0", Busy, Done, DivZero);
        end
    endtask

    task automatic test_random();
        int lat; bit bok; logic [31:0] hi, lo, eq, er, a, b; logic dz, s;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom);
            case ($urandom_range(0, 3))
                0: b = $urandom_range(1, 20);
                1: b = -$urandom_range(1, 20);
                2: a = $urandom_range(0, 1000);
                default: ;
            endcase
            if (b == 0) b = 32'd1;
            model(a, b, s, eq, er);
            do_div(a, b, s, lat, bok, hi, lo, dz);
            tests++;
            if (lat !== 34 || lo !== eq || hi !== er || dz !== 1'b0) begin
                fails++;
                $display("FAIL random%0d: A=%h B=%h S=%b -> cycle=%0d Lo=%h Hi=%h DivZero=%b, expected cycle=34 Lo=%h Hi=%h DivZero=0",
                         i, a, b, s, lat, lo, hi, dz, eq, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
